// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;
  localparam int N_BEATS  = S_LINE / S_BURST;
  localparam int S_OFFSET = 5;
  localparam int S_ADDR   = 32;
  localparam int S_CNT    = $clog2(N_BEATS);

  typedef logic [S_LINE-1:0]  cacheline_t;
  typedef logic [S_BURST-1:0] burst_t;
  typedef logic [S_CNT-1:0]   beat_cnt_t;

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(N_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  // Memory bursts always start on a line boundary.
  function automatic logic [S_ADDR-1:0] align_addr(input logic [S_ADDR-1:0] addr);
    return {addr[S_ADDR-1:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor_line_shift_buffer.sv
// Line storage and beat counter: assembles read beats into a line and
// serves the latched writeback line one beat at a time.
module cacheline_adaptor_line_shift_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [S_LINE-1:0]  line_i,
  input  logic               capture_i,
  input  logic [S_BURST-1:0] burst_i,
  input  logic               adv_i,
  input  logic               clr_i,
  output logic [S_LINE-1:0]  rd_line_o,
  output logic [S_BURST-1:0] wr_beat_o,
  output logic [S_CNT-1:0]   cnt_o
);

  // The read line lives apart from the writeback line so line_o keeps the
  // last read result across intervening writebacks.
  burst_t [N_BEATS-1:0] rd_beats_q, rd_beats_d;
  burst_t [N_BEATS-1:0] wr_beats_q, wr_beats_d;
  beat_cnt_t            cnt_q, cnt_d;

  always_comb begin
    rd_beats_d = rd_beats_q;
    wr_beats_d = wr_beats_q;
    cnt_d      = cnt_q;
    if (load_i) begin
      wr_beats_d = line_i;
    end
    if (capture_i) begin
      rd_beats_d[cnt_q] = burst_i;
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_beats_q <= '0;
      wr_beats_q <= '0;
      cnt_q      <= '0;
    end else begin
      rd_beats_q <= rd_beats_d;
      wr_beats_q <= wr_beats_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_line_o = rd_beats_q;
  assign wr_beat_o = wr_beats_q[cnt_q];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read/writeback into a 4-beat 64-bit
// memory burst and returns a single-cycle completion pulse.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [S_LINE-1:0]   line_i,
  output logic [S_LINE-1:0]   line_o,
  input  logic [S_ADDR-1:0]   address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [S_BURST-1:0]  burst_i,
  output logic [S_BURST-1:0]  burst_o,
  output logic [S_ADDR-1:0]   address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i,
  output adaptor_state_t      state_o
);

  // Handshakes: the cache holds read_i/write_i until the one-cycle resp_o;
  // read_o/write_o stay high until the 4th beat, and each cycle with
  // resp_i high transfers exactly one beat (resp_i low stalls the burst).

  adaptor_state_t    state_q, state_d;
  logic [S_ADDR-1:0] addr_q, addr_d;
  logic              load_wr, capture, adv, clr;
  beat_cnt_t         cnt;
  burst_t            wr_beat;

  cacheline_adaptor_line_shift_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_wr),
    .line_i    (line_i),
    .capture_i (capture),
    .burst_i   (burst_i),
    .adv_i     (adv),
    .clr_i     (clr),
    .rd_line_o (line_o),
    .wr_beat_o (wr_beat),
    .cnt_o     (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    load_wr   = 1'b0;
    capture   = 1'b0;
    adv       = 1'b0;
    clr       = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    case (state_q)
      IDLE: begin
        // A dirty writeback wins if the cache ever raises both requests.
        if (write_i) begin
          state_d = WRITE;
          addr_d  = align_addr(address_i);
          load_wr = 1'b1;
        end else if (read_i) begin
          state_d = READ;
          addr_d  = align_addr(address_i);
        end
      end
      READ: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (resp_i) begin
          capture = 1'b1;
          adv     = 1'b1;
          if (cnt == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = wr_beat;
        if (resp_i) begin
          adv = 1'b1;
          if (cnt == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule
